// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus master.
// Contents: bus widths (ADDR_W, DATA_W) and the master FSM state type.
package reg_bus_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StRsp
    } state_e;

endpackage

// File: rtl/reg_bus_master.sv
// Burst command front-end driving a simple single-cycle register bus.
// A command (write/read, start address, beat count - 1) is turned into a series
// of register-bus cycles. Writes consume one wd beat per bus write and return a
// single response; reads return one response per beat, last beat flagged.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   cmd_valid/ready/write/addr/len command channel (len = beats - 1)
//   wd_valid/ready/data           write-data channel
//   rsp_valid/ready/data/last     response channel
//   wr_en, rd_en, addr            register-bus strobes and address
//   write_data, read_data         register-bus data (read_data combinational from addr)
//   busy                          high whenever the FSM is not idle
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int unsigned RD_LAT = 0  // cycles after rd_en at which read_data is sampled, 0..3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,

    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,

    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,

    output logic              busy
);

    // Value of the wait counter on the cycle read_data is captured.
    localparam logic [1:0] LAT_LAST = 2'((RD_LAT == 0) ? 0 : RD_LAT - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          beats_q;
    logic                dir_q;
    logic [1:0]          lat_q;
    logic [DATA_W-1:0]   data_q;

    // Writes answer once per command; reads flag only the final beat.
    logic last_beat;
    assign last_beat = dir_q || (beats_q == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beats_q <= '0;
            dir_q   <= 1'b0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        beats_q <= cmd_len;
                        dir_q   <= cmd_write;
                        state_q <= cmd_write ? StWr : StRd;
                    end
                end
                StWr: begin
                    if (wd_valid) begin
                        addr_q <= addr_q + 1'b1;
                        if (beats_q == 8'd0) begin
                            data_q  <= '0;
                            state_q <= StRsp;
                        end else begin
                            beats_q <= beats_q - 1'b1;
                        end
                    end
                end
                StRd: begin
                    if (RD_LAT == 0) begin
                        data_q  <= read_data;
                        state_q <= StRsp;
                    end else begin
                        lat_q   <= '0;
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    // addr stays on addr_q, so read_data is still for this beat
                    if (lat_q == LAT_LAST) begin
                        data_q  <= read_data;
                        state_q <= StRsp;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        if (last_beat) begin
                            state_q <= StIdle;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            beats_q <= beats_q - 1'b1;
                            state_q <= StRd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        cmd_ready  = (state_q == StIdle) && !rst;
        wd_ready   = 1'b0;
        wr_en      = 1'b0;
        write_data = '0;
        rd_en      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_last   = 1'b0;
        busy       = (state_q != StIdle);
        addr       = addr_q;
        case (state_q)
            StWr: begin
                wd_ready   = 1'b1;
                wr_en      = wd_valid;
                write_data = wd_data;
            end
            StRd: begin
                rd_en = 1'b1;
            end
            StRsp: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                rsp_last  = last_beat;
            end
            default: begin
            end
        endcase
    end

endmodule
